// File: rtl/tmds_pkg.sv
// tmds_pkg: control tokens, ctrl encoding and alignment FSM states shared by the TMDS encoder and decoder
package tmds_pkg;
  localparam logic [9:0] TOKEN_C00 = 10'b1101010100;
  localparam logic [9:0] TOKEN_C01 = 10'b0010101011;
  localparam logic [9:0] TOKEN_C10 = 10'b0101010100;
  localparam logic [9:0] TOKEN_C11 = 10'b1010101011;
  typedef enum logic [1:0] {CTRL_00, CTRL_01, CTRL_10, CTRL_11} ctrl_e;
  typedef enum logic [1:0] {SEARCH, SLIP_WAIT, LOCKED} state_e;
endpackage

// File: rtl/tmds_word_decode.sv
// tmds_word_decode: combinational 10b TMDS word to {is_token, ctrl, data}
module tmds_word_decode
  import tmds_pkg::*;
(
  input  logic [9:0] word,
  output logic       is_token,
  output logic [1:0] ctrl,
  output logic [7:0] data
);
  logic [7:0] d;
  assign d = word[9] ? ~word[7:0] : word[7:0];
  assign data = {word[8] ? d[7:1] ^ d[6:0] : ~(d[7:1] ^ d[6:0]), d[0]};
  assign is_token = word == TOKEN_C00 || word == TOKEN_C01 || word == TOKEN_C10 || word == TOKEN_C11;
  assign ctrl = word == TOKEN_C01 ? CTRL_01 : word == TOKEN_C10 ? CTRL_10 : word == TOKEN_C11 ? CTRL_11 : CTRL_00;
endmodule

// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder: TMDS word alignment via bitslip plus 10b->8b/ctrl/DE decode for one channel
module tmds_channel_decoder
  import tmds_pkg::*;
#(
  parameter int SEARCH_WINDOW = 4096,
  parameter int CTRL_RUN      = 16,
  parameter int SLIP_SETTLE   = 8,
  parameter int LOSS_WINDOW   = 8192
) (
  input  logic       pixel_clk,
  input  logic       sys_rst_n,
  input  logic [9:0] tmds_word_in,
  output logic       bitslip,
  output logic [3:0] slip_cnt,
  output logic       aligned,
  output logic       video_de,
  output logic [1:0] video_ctrl,
  output logic [7:0] video_data
);
  localparam int WW = $clog2(SEARCH_WINDOW);
  localparam int RW = $clog2(CTRL_RUN);
  localparam int SW = $clog2(SLIP_SETTLE);
  localparam int GW = $clog2(LOSS_WINDOW);
  localparam logic [WW-1:0] WIN_MAX    = WW'(SEARCH_WINDOW - 1);
  localparam logic [RW-1:0] RUN_MAX    = RW'(CTRL_RUN - 1);
  localparam logic [SW-1:0] SETTLE_MAX = SW'(SLIP_SETTLE - 1);
  localparam logic [GW-1:0] GAP_MAX    = GW'(LOSS_WINDOW - 1);
  logic [9:0]    w1;
  logic          is_token;
  logic [1:0]    tok_ctrl;
  logic [7:0]    dec_data;
  state_e        state, state_nxt;
  logic [WW-1:0] win_cnt;
  logic [RW-1:0] run_cnt;
  logic [SW-1:0] settle_cnt;
  logic [GW-1:0] gap_cnt;
  logic          lock, slip, settled, lost;
  tmds_word_decode u_dec (
    .word     (w1),
    .is_token (is_token),
    .ctrl     (tok_ctrl),
    .data     (dec_data)
  );
  assign aligned = state == LOCKED;
  always_comb begin
    lock      = state == SEARCH && is_token && run_cnt == RUN_MAX;
    slip      = state == SEARCH && !lock && win_cnt == WIN_MAX;
    settled   = state == SLIP_WAIT && settle_cnt == SETTLE_MAX;
    lost      = state == LOCKED && !is_token && gap_cnt == GAP_MAX;
    state_nxt = lock ? LOCKED : slip ? SLIP_WAIT : (settled || lost) ? SEARCH : state;
  end
  always_ff @(posedge pixel_clk) begin
    if (!sys_rst_n) begin
      w1         <= '0;
      state      <= SEARCH;
      bitslip    <= 1'b0;
      slip_cnt   <= '0;
      win_cnt    <= '0;
      run_cnt    <= '0;
      settle_cnt <= '0;
      gap_cnt    <= '0;
      video_de   <= 1'b0;
      video_ctrl <= '0;
      video_data <= '0;
    end else begin
      w1         <= tmds_word_in;
      state      <= state_nxt;
      bitslip    <= slip;
      slip_cnt   <= !slip ? slip_cnt : slip_cnt == 4'd9 ? 4'd0 : slip_cnt + 4'd1;
      win_cnt    <= state != SEARCH ? '0 : win_cnt + WW'(win_cnt != WIN_MAX);
      run_cnt    <= (state != SEARCH || !is_token) ? '0 : run_cnt + RW'(run_cnt != RUN_MAX);
      settle_cnt <= (state != SLIP_WAIT || settled) ? '0 : settle_cnt + SW'(settle_cnt != SETTLE_MAX);
      gap_cnt    <= (state != LOCKED || is_token) ? '0 : gap_cnt + GW'(gap_cnt != GAP_MAX);
      video_de   <= aligned && !is_token;
      video_ctrl <= !aligned ? '0 : is_token ? tok_ctrl : video_ctrl;
      video_data <= (aligned && !is_token) ? dec_data : '0;
    end
  end
endmodule

// File: tb/tb_tmds_channel_decoder.sv
// tb_tmds_channel_decoder: directed self-checking bench for tmds_channel_decoder
module tb_tmds_channel_decoder;
  import tmds_pkg::*;
  logic       pixel_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [9:0] tmds_word_in = '0;
  logic       bitslip, aligned, video_de;
  logic [3:0] slip_cnt;
  logic [1:0] video_ctrl;
  logic [7:0] video_data;
  int checks = 0;
  int errors = 0;
  always #5 pixel_clk = ~pixel_clk;
  tmds_channel_decoder dut (
    .pixel_clk    (pixel_clk),
    .sys_rst_n    (sys_rst_n),
    .tmds_word_in (tmds_word_in),
    .bitslip      (bitslip),
    .slip_cnt     (slip_cnt),
    .aligned      (aligned),
    .video_de     (video_de),
    .video_ctrl   (video_ctrl),
    .video_data   (video_data)
  );
  task automatic tick(input logic [9:0] w);
    tmds_word_in = w;
    @(posedge pixel_clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [9:0] rotl(input logic [9:0] x, input int k);
    return (x << k) | (x >> (10 - k));
  endfunction
  function automatic logic [9:0] nontok();
    logic [9:0] w;
    w = 10'($urandom);
    return (w == TOKEN_C00 || w == TOKEN_C01 || w == TOKEN_C10 || w == TOKEN_C11) ? w ^ 10'h001 : w;
  endfunction
  initial begin
    int nslip, pulses, last, cyc, off;
    repeat (3) tick(TOKEN_C00);
    check("rst_bitslip", 32'(bitslip), 0);
    check("rst_slip_cnt", 32'(slip_cnt), 0);
    check("rst_aligned", 32'(aligned), 0);
    check("rst_de", 32'(video_de), 0);
    check("rst_ctrl", 32'(video_ctrl), 0);
    check("rst_data", 32'(video_data), 0);
    sys_rst_n = 1'b1;
    repeat (16) tick(TOKEN_C00);
    check("prelock_aligned", 32'(aligned), 0);
    tick(TOKEN_C00);
    check("lock_aligned", 32'(aligned), 1);
    tick(TOKEN_C00);
    check("tok00_de", 32'(video_de), 0);
    check("tok00_ctrl", 32'(video_ctrl), 0);
    tick(TOKEN_C11);
    check("tok00b_de", 32'(video_de), 0);
    tick(10'b0100000000);
    check("tok11_de", 32'(video_de), 0);
    check("tok11_ctrl", 32'(video_ctrl), 3);
    tick(10'b1011111111);
    check("dec00_de", 32'(video_de), 1);
    check("dec00_data", 32'(video_data), 32'h00);
    check("dec00_ctrl_hold", 32'(video_ctrl), 3);
    tick(10'b0100001111);
    check("decfe_de", 32'(video_de), 1);
    check("decfe_data", 32'(video_data), 32'hFE);
    check("decfe_ctrl_hold", 32'(video_ctrl), 3);
    tick(TOKEN_C00);
    check("dec11_data", 32'(video_data), 32'h11);
    tick(TOKEN_C00);
    check("tokend_de", 32'(video_de), 0);
    check("tokend_ctrl", 32'(video_ctrl), 0);
    check("tokend_data", 32'(video_data), 0);
    nslip = 0;
    for (int i = 0; i < 8192; i++) begin
      tick(nontok());
      if (bitslip) nslip++;
    end
    check("loss_pre_aligned", 32'(aligned), 1);
    check("locked_no_slip", 32'(nslip), 0);
    tick(nontok());
    check("loss_aligned", 32'(aligned), 0);
    tick(nontok());
    check("loss_de", 32'(video_de), 0);
    check("loss_data", 32'(video_data), 0);
    nslip = 0;
    for (int i = 0; i < 4094; i++) begin
      tick(nontok());
      if (bitslip) nslip++;
    end
    check("search_no_early_slip", 32'(nslip), 0);
    tick(nontok());
    check("resume_bitslip", 32'(bitslip), 1);
    check("resume_slip_cnt", 32'(slip_cnt), 1);
    sys_rst_n = 1'b0;
    tick(TOKEN_C00);
    check("midslip_bitslip", 32'(bitslip), 0);
    check("midslip_slip_cnt", 32'(slip_cnt), 0);
    check("midslip_aligned", 32'(aligned), 0);
    check("midslip_state", 32'(dut.state), 32'(SEARCH));
    sys_rst_n = 1'b1;
    off = 3;
    pulses = 0;
    last = 0;
    cyc = 0;
    for (int i = 0; i < 40000 && !aligned; i++) begin
      tick(rotl(TOKEN_C00, off));
      cyc++;
      if (bitslip) begin
        check("slip_interval", 32'(cyc - last), pulses == 0 ? 32'd4096 : 32'd4104);
        last = cyc;
        pulses++;
        off = (off + 1) % 10;
      end
    end
    check("rot_aligned", 32'(aligned), 1);
    check("rot_pulses", 32'(pulses), 7);
    check("rot_slip_cnt", 32'(slip_cnt), 7);
    pulses = 0;
    for (int i = 0; i < 20497; i++) begin
      tick(nontok());
      if (bitslip) begin
        pulses++;
        if (pulses == 2) check("wrap_slip_cnt9", 32'(slip_cnt), 9);
      end
    end
    check("wrap_pulses", 32'(pulses), 3);
    check("wrap_bitslip", 32'(bitslip), 1);
    check("wrap_slip_cnt0", 32'(slip_cnt), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end
endmodule
